seq_pair_processor: RTL and testbench

Parametrised successor to the fixed 8-entry memory-A → pairwise add/sub → 4-entry memory-B datapath. Host streams DEPTH_A words into internal memory A, then pulses start. An FSM walks A in pairs (A[2k], A[2k+1]), applies a runtime-selected operation and writes the result to B[k]. Results are read back through a registered port; one start/busy/done handshake sequences each batch.

---
 rtl/seq_pair_pkg.sv | 27 ++
 rtl/seq_pair_processor_if.sv | 34 +++
 rtl/pair_alu.sv | 58 +++++
 rtl/seq_pair_processor.sv | 182 ++++++++++++++++++
 tb/tb_seq_pair_processor.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_pair_pkg.sv
// Shared types for the pair processor: operation encodings, FSM states and
// a width helper used for address/pointer sizing.
package seq_pair_pkg;

    localparam int unsigned OP_W = 2;

    // Operation applied to each (A[2k], A[2k+1]) pair.
    typedef enum logic [OP_W-1:0] {
        OP_COND = 2'b00,   // a >= b ? a - b : a + b
        OP_ADD  = 2'b01,   // a + b
        OP_SUB  = 2'b10,   // a - b
        OP_ABS  = 2'b11    // |a - b|
    } opMode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_DONE
    } state_t;

    // Address width for a memory of the given depth, never narrower than 1 bit.
    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/seq_pair_processor_if.sv
// Host-side bus of the pair processor.
//   master (host): load_valid, load_data, start, op_mode, rd_addr out;
//                  load_ready, busy, done, overflow, rd_data in.
//   slave  (core): the mirror image.
interface seq_pair_processor_if
    import seq_pair_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH_A = 8
);
    localparam int unsigned RD_W = addrWidth(DEPTH_A / 2);

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              start;
    logic [OP_W-1:0]   op_mode;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [RD_W-1:0]   rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output load_valid, load_data, start, op_mode, rd_addr,
        input  load_ready, busy, done, overflow, rd_data
    );

    modport slave (
        input  load_valid, load_data, start, op_mode, rd_addr,
        output load_ready, busy, done, overflow, rd_data
    );

endinterface

// File: rtl/pair_alu.sv
// Combinational pair operator.
//   a, b   : unsigned operands
//   mode   : operation select
//   result : a op b, modulo 2^DATA_W
//   ovf    : carry on an addition, borrow on a plain subtraction
module pair_alu
    import seq_pair_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opMode_t           mode,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);
    logic [DATA_W:0]   sumExt;
    logic [DATA_W-1:0] diffAB;
    logic [DATA_W-1:0] diffBA;
    logic              aGeB;

    assign sumExt = {1'b0, a} + {1'b0, b};
    assign diffAB = a - b;
    assign diffBA = b - a;
    assign aGeB   = (a >= b);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (mode)
            // Conditional mode only subtracts when it cannot borrow.
            OP_COND: begin
                if (aGeB) begin
                    result = diffAB;
                end else begin
                    result = sumExt[DATA_W-1:0];
                    ovf    = sumExt[DATA_W];
                end
            end
            OP_ADD: begin
                result = sumExt[DATA_W-1:0];
                ovf    = sumExt[DATA_W];
            end
            OP_SUB: begin
                result = diffAB;
                ovf    = !aGeB;
            end
            OP_ABS: begin
                result = aGeB ? diffAB : diffBA;
            end
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_pair_processor.sv
// Pairwise processor: the host streams DEPTH_A words into memory A, pulses
// start, and the FSM reduces each pair (A[2k], A[2k+1]) into B[k].
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : load stream, start/op_mode, busy/done/overflow status and
//                  registered B readback (1-cycle latency)
module seq_pair_processor
    import seq_pair_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH_A = 8
) (
    input  logic                clock,
    input  logic                reset,
    seq_pair_processor_if.slave bus
);
    localparam int unsigned DEPTH_B  = DEPTH_A / 2;
    localparam int unsigned A_ADDR_W = addrWidth(DEPTH_A);
    localparam int unsigned B_ADDR_W = addrWidth(DEPTH_B);
    localparam int unsigned PTR_W    = A_ADDR_W + 1;

    state_t              state;
    state_t              stateNext;

    logic [DATA_W-1:0]   aMem [DEPTH_A];
    logic [DATA_W-1:0]   bMem [DEPTH_B];

    logic [PTR_W-1:0]    loadPtr;
    logic [PTR_W-1:0]    loadPtrNext;
    logic [B_ADDR_W-1:0] pairIdx;
    logic [B_ADDR_W-1:0] pairIdxNext;
    opMode_t             modeReg;
    logic [DATA_W-1:0]   holdReg;
    logic                overflowReg;
    logic                overflowNext;
    logic                busyReg;
    logic                doneReg;
    logic                loadReadyReg;
    logic [DATA_W-1:0]   rdDataReg;

    logic                inIdle;
    logic                isFull;
    logic                loadFire;
    logic                startFire;
    logic                lastPair;
    logic                holdEn;
    logic                bWrEn;
    logic [A_ADDR_W-1:0] firstAddr;
    logic [A_ADDR_W-1:0] secondAddr;
    logic [DATA_W-1:0]   aluRes;
    logic                aluOvf;

    // Handshake decode. When full, load is never accepted, so a coincident
    // start wins; when not full, start is never accepted, so the load wins.
    assign inIdle     = (state == ST_IDLE);
    assign isFull     = (loadPtr == PTR_W'(DEPTH_A));
    assign loadFire   = inIdle && bus.load_valid && !isFull;
    assign startFire  = inIdle && bus.start && isFull;
    assign lastPair   = (pairIdx == B_ADDR_W'(DEPTH_B - 1));
    assign firstAddr  = A_ADDR_W'({pairIdx, 1'b0});
    assign secondAddr = A_ADDR_W'({pairIdx, 1'b1});

    pair_alu #(
        .DATA_W (DATA_W)
    ) uAlu (
        .a      (holdReg),
        .b      (aMem[secondAddr]),
        .mode   (modeReg),
        .result (aluRes),
        .ovf    (aluOvf)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (startFire) stateNext = ST_FIRST;
            ST_FIRST:  stateNext = ST_SECOND;
            ST_SECOND: stateNext = lastPair ? ST_DONE : ST_FIRST;
            ST_DONE:   stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes and next values of counters/flags.
    always_comb begin
        holdEn       = 1'b0;
        bWrEn        = 1'b0;
        loadPtrNext  = loadPtr;
        pairIdxNext  = pairIdx;
        overflowNext = overflowReg;
        case (state)
            ST_IDLE: begin
                if (loadFire) begin
                    loadPtrNext = loadPtr + PTR_W'(1);
                end
                if (startFire) begin
                    pairIdxNext  = '0;
                    overflowNext = 1'b0;
                end
            end
            ST_FIRST: begin
                holdEn = 1'b1;
            end
            ST_SECOND: begin
                bWrEn        = 1'b1;
                pairIdxNext  = pairIdx + B_ADDR_W'(1);
                overflowNext = overflowReg | aluOvf;
            end
            ST_DONE: begin
                // Re-arm loading for the next batch; A itself is kept.
                loadPtrNext = '0;
            end
            default: begin
                loadPtrNext = '0;
            end
        endcase
    end

    // Control registers and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            loadPtr      <= '0;
            pairIdx      <= '0;
            overflowReg  <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            loadReadyReg <= 1'b1;
            modeReg      <= OP_COND;
            holdReg      <= '0;
            rdDataReg    <= '0;
        end else begin
            loadPtr      <= loadPtrNext;
            pairIdx      <= pairIdxNext;
            overflowReg  <= overflowNext;
            busyReg      <= (stateNext != ST_IDLE);
            doneReg      <= (stateNext == ST_DONE);
            loadReadyReg <= (stateNext == ST_IDLE) && (loadPtrNext < PTR_W'(DEPTH_A));
            if (startFire) begin
                modeReg <= opMode_t'(bus.op_mode);
            end
            if (holdEn) begin
                holdReg <= aMem[firstAddr];
            end
            // Reads the pre-write contents when B is written the same cycle.
            rdDataReg <= bMem[bus.rd_addr];
        end
    end

    // Memory A: host-loaded, never reset.
    always_ff @(posedge clock) begin
        if (!reset && loadFire) begin
            aMem[A_ADDR_W'(loadPtr)] <= bus.load_data;
        end
    end

    // Memory B: result store, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_B); i++) begin
                bMem[i] <= '0;
            end
        end else if (bWrEn) begin
            bMem[pairIdx] <= aluRes;
        end
    end

    assign bus.load_ready = loadReadyReg;
    assign bus.busy       = busyReg;
    assign bus.done       = doneReg;
    assign bus.overflow   = overflowReg;
    assign bus.rd_data    = rdDataReg;

endmodule

// File: tb/tb_seq_pair_processor.sv
// Directed bench for seq_pair_processor with DATA_W=8, DEPTH_A=8.
module tb_seq_pair_processor;
    import seq_pair_pkg::*;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH_A = 8;

    typedef struct {
        logic [1:0]      mode;
        logic [3:0][7:0] expB;
        logic            expOvf;
        logic            pokeStart;
        logic            pokeLoad;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clock = ~clock;

    seq_pair_processor_if #(.DATA_W(DATA_W), .DEPTH_A(DEPTH_A)) bus ();

    seq_pair_processor #(
        .DATA_W  (DATA_W),
        .DEPTH_A (DEPTH_A)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic loadRange(input logic [7:0][7:0] w, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = w[i];
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic readAll(input string tag, input logic [3:0][7:0] expB);
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i);
            tick();
            check($sformatf("%s rd B[%0d]", tag, i), 32'(bus.rd_data), 32'(expB[i]));
        end
    endtask

    // Start a run at edge t and follow it over cycles t+1..t+10.
    task automatic runCheck(input string tag, input logic [1:0] mode, input logic [3:0][7:0] expB,
                            input logic expOvf, input logic pokeStart, input logic pokeLoad,
                            input logic [7:0] oldB2);
        int         doneAt;
        int         doneCnt;
        int         busyBad;
        int         readyBad;
        logic [7:0] rdOld;
        logic [7:0] rdNew;
        doneAt   = -1;
        doneCnt  = 0;
        busyBad  = 0;
        readyBad = 0;
        rdOld    = '0;
        rdNew    = '0;
        bus.rd_addr = 2'd2;
        bus.op_mode = mode;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.op_mode = ~mode;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
                bus.start      = pokeStart && (k == 3 || k == 6);
                bus.load_valid = pokeLoad;
                bus.load_data  = 8'hFF;
                tick();
            end
            if (bus.done === 1'b1) begin
                doneCnt++;
                doneAt = k;
            end
            if (bus.busy !== (k <= 9)) busyBad++;
            if (bus.load_ready !== (k >= 10)) readyBad++;
            if (k == 7) rdOld = bus.rd_data;
            if (k == 8) rdNew = bus.rd_data;
        end
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        check({tag, " done cycle"}, 32'(doneAt), 32'd9);
        check({tag, " done count"}, 32'(doneCnt), 32'd1);
        check({tag, " busy window"}, 32'(busyBad), 32'd0);
        check({tag, " load_ready window"}, 32'(readyBad), 32'd0);
        check({tag, " overflow"}, 32'(bus.overflow), 32'(expOvf));
        check({tag, " rd B2 old"}, 32'(rdOld), 32'(oldB2));
        check({tag, " rd B2 new"}, 32'(rdNew), 32'(expB[2]));
        readAll(tag, expB);
    endtask

    initial begin
        logic [7:0][7:0] stdA;
        logic [7:0][7:0] altA;
        logic [7:0]      prevB2;
        vec_t            vecs[4];
        int              doneSeen;

        stdA = {8'd7, 8'd7, 8'd100, 8'd200, 8'd9, 8'd5, 8'd3, 8'd10};
        altA = {8'd7, 8'd7, 8'd9, 8'd5, 8'd3, 8'd10, 8'd100, 8'd200};

        vecs[0] = '{mode: 2'b00, expB: {8'd0, 8'd100, 8'd14, 8'd7},  expOvf: 1'b0, pokeStart: 1'b1, pokeLoad: 1'b0};
        vecs[1] = '{mode: 2'b01, expB: {8'd14, 8'd44, 8'd14, 8'd13}, expOvf: 1'b1, pokeStart: 1'b0, pokeLoad: 1'b1};
        vecs[2] = '{mode: 2'b10, expB: {8'd0, 8'd100, 8'd252, 8'd7}, expOvf: 1'b1, pokeStart: 1'b1, pokeLoad: 1'b1};
        vecs[3] = '{mode: 2'b11, expB: {8'd0, 8'd100, 8'd4, 8'd7},   expOvf: 1'b0, pokeStart: 1'b0, pokeLoad: 1'b0};

        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.op_mode    = '0;
        bus.rd_addr    = '0;

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        check("reset rd_data", 32'(bus.rd_data), 32'd0);
        check("reset load_ready", 32'(bus.load_ready), 32'd1);
        readAll("reset", '0);

        // One run per operation on the standard data set.
        prevB2 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            loadRange(stdA, 0, 8);
            check($sformatf("vec%0d full", i), 32'(bus.load_ready), 32'd0);
            runCheck($sformatf("vec%0d", i), vecs[i].mode, vecs[i].expB, vecs[i].expOvf,
                     vecs[i].pokeStart, vecs[i].pokeLoad, prevB2);
            prevB2 = vecs[i].expB[2];
        end

        // Start before A is full is ignored; a start alongside a load lets the load win.
        loadRange(stdA, 0, 5);
        bus.op_mode = 2'b01;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        check("partial start busy", 32'(bus.busy), 32'd0);
        check("partial load_ready", 32'(bus.load_ready), 32'd1);
        tick();
        check("partial busy later", 32'(bus.busy), 32'd0);
        bus.load_valid = 1'b1;
        bus.load_data  = stdA[5];
        bus.start      = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        check("load+start busy", 32'(bus.busy), 32'd0);
        check("load+start ready", 32'(bus.load_ready), 32'd1);
        loadRange(stdA, 6, 2);
        check("partial now full", 32'(bus.load_ready), 32'd0);
        // Full: a coincident load offer is dropped and start wins.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        runCheck("late", 2'b00, vecs[0].expB, 1'b0, 1'b1, 1'b1, prevB2);

        // Reset in the middle of a run.
        loadRange(altA, 0, 8);
        bus.op_mode = 2'b01;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        tick();
        tick();
        check("midrun busy before", 32'(bus.busy), 32'd1);
        check("midrun overflow before", 32'(bus.overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun busy", 32'(bus.busy), 32'd0);
        check("midrun done", 32'(bus.done), 32'd0);
        check("midrun overflow", 32'(bus.overflow), 32'd0);
        check("midrun load_ready", 32'(bus.load_ready), 32'd1);
        doneSeen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) doneSeen++;
        end
        check("midrun no done", 32'(doneSeen), 32'd0);
        readAll("midrun", '0);
        loadRange(stdA, 0, 8);
        runCheck("afterrst", 2'b00, vecs[0].expB, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
